// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: request-to-send, start bit, 8 data bits LSB first,
// odd parity, stop bit and device acknowledge, timed by the device's filtered clock.
//   state | meaning
//   idle  | lines released, tx_idle high, waiting for wr_ps2
//   rts   | ps2c held low for RTS_CYCLES cycles
//   start | ps2d low, waiting for first device clock fall
//   data  | shifting out 8 data bits and parity on device clock falls
//   stop  | lines released, ack sampled on next fall
//   done  | one-cycle tx_done_tick
module ps2_tx #(
    parameter int RTS_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2d,
    inout  wire        ps2c,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);

    localparam int CW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;
    localparam logic [CW-1:0] RTS_LOAD = CW'(RTS_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    filter_q, filter_d;
    logic          f_ps2c_q, f_ps2c_d;
    logic [CW-1:0] rts_cnt_q, rts_cnt_d;
    logic [3:0]    n_q, n_d;
    logic [8:0]    sh_q, sh_d;
    logic          ack_err_q, ack_err_d;
    logic          fall_edge;
    logic          ps2c_low;
    logic          ps2d_low;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            filter_q  <= '0;
            f_ps2c_q  <= 1'b0;
            rts_cnt_q <= '0;
            n_q       <= '0;
            sh_q      <= '0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            filter_q  <= filter_d;
            f_ps2c_q  <= f_ps2c_d;
            rts_cnt_q <= rts_cnt_d;
            n_q       <= n_d;
            sh_q      <= sh_d;
            ack_err_q <= ack_err_d;
        end
    end

    // Filtered clock only moves after eight agreeing samples, so short glitches are ignored.
    always_comb begin
        filter_d = {ps2c, filter_q[7:1]};
        if (filter_q == 8'hFF) begin
            f_ps2c_d = 1'b1;
        end else if (filter_q == 8'h00) begin
            f_ps2c_d = 1'b0;
        end else begin
            f_ps2c_d = f_ps2c_q;
        end
        fall_edge = f_ps2c_q & ~f_ps2c_d;
    end

    always_comb begin
        state_d      = state_q;
        rts_cnt_d    = rts_cnt_q;
        n_d          = n_q;
        sh_d         = sh_q;
        ack_err_d    = ack_err_q;
        tx_idle      = 1'b0;
        tx_done_tick = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_idle = 1'b1;
                if (wr_ps2) begin
                    sh_d      = {~^din, din};
                    rts_cnt_d = RTS_LOAD;
                    ack_err_d = 1'b0;
                    state_d   = ST_RTS;
                end
            end
            ST_RTS: begin
                if (rts_cnt_q == '0) begin
                    state_d = ST_START;
                end else begin
                    rts_cnt_d = rts_cnt_q - 1'b1;
                end
            end
            ST_START: begin
                if (fall_edge) begin
                    n_d     = 4'd8;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fall_edge) begin
                    sh_d = {1'b0, sh_q[8:1]};
                    if (n_q == 4'd0) begin
                        state_d = ST_STOP;
                    end else begin
                        n_d = n_q - 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (fall_edge) begin
                    ack_err_d = ps2d;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                tx_done_tick = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Drives depend only on registered state, so reset releases both lines immediately.
    always_comb begin
        ps2c_low = (state_q == ST_RTS);
        ps2d_low = (state_q == ST_START) || ((state_q == ST_DATA) && !sh_q[0]);
    end

    assign ps2c    = ps2c_low ? 1'b0 : 1'bz;
    assign ps2d    = ps2d_low ? 1'b0 : 1'bz;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: behavioural PS/2 device with pull-ups, randomized frames,
// and a per-cycle comparison against a transaction-level model of the transmitter.
module tb_ps2_tx;

    localparam int RTS = 4;
    localparam int H   = 20;  // device half-period in clk cycles (scaled 10 kHz clock)

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    wire        ps2c;
    wire        ps2d;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       ack_err;
    logic       dev_c_drv;
    logic       dev_d_drv;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c_drv ? 1'b0 : 1'bz;
    assign ps2d = dev_d_drv ? 1'b0 : 1'bz;

    ps2_tx #(.RTS_CYCLES(RTS)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2d         (ps2d),
        .ps2c         (ps2c),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .ack_err      (ack_err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit exp_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    // transaction-level model state
    bit m_busy     = 0;
    int m_rts_left = 0;
    bit m_chk_rel  = 0;
    bit m_last_ack = 0;
    bit prev_tick  = 0;
    bit cur_ack    = 1;
    int done_cnt   = 0;
    int fall11_cyc = -1000;
    int pulse_cnt  = 0;

    always @(negedge clk) begin
        bit was_busy;
        if (reset) begin
            m_busy     = 0;
            m_rts_left = 0;
            m_chk_rel  = 0;
            m_last_ack = 0;
            prev_tick  = 0;
        end else begin
            was_busy = m_busy;
            chk("tx_idle", tx_idle, !m_busy);
            if (tx_done_tick) begin
                chk("done_while_busy", m_busy, 1);
                chk("done_single_cycle", prev_tick, 0);
                chk("ack_err_at_done", ack_err, !cur_ack);
                chk("done_latency", (cyc - fall11_cyc >= 8) && (cyc - fall11_cyc <= 10), 1);
                done_cnt++;
                m_busy     = 0;
                m_last_ack = !cur_ack;
            end else if (m_busy) begin
                chk("ack_err_busy", ack_err, 0);
            end else begin
                chk("ack_err_idle", ack_err, m_last_ack);
            end
            if (m_rts_left > 0) begin
                chk("rts_low", ps2c, 0);
                m_rts_left--;
                m_chk_rel = (m_rts_left == 0);
            end else if (m_chk_rel) begin
                chk("rts_release", ps2c, 1);
                m_chk_rel = 0;
            end
            if (!m_busy && !dev_c_drv) chk("idle_ps2c", ps2c, 1);
            if (!m_busy && !dev_d_drv) chk("idle_ps2d", ps2d, 1);
            prev_tick = tx_done_tick;
            if (!was_busy && wr_ps2) begin
                m_busy     = 1;
                m_rts_left = RTS;
            end
        end
    end

    task automatic device_frame(input int max_pulses, input bit ack, input bit glitch,
                                output logic [9:0] bits, output int rts_len, output bit start_ok);
        int t;
        bits     = 'x;
        rts_len  = 0;
        start_ok = 0;
        t        = 0;
        @(negedge clk);
        while (ps2c !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (ps2c !== 1'b0) begin
            chk("dev_rts_seen", ps2c, 0);
            return;
        end
        while (ps2c === 1'b0 && rts_len < 100) begin
            rts_len++;
            @(negedge clk);
        end
        start_ok = (ps2d === 1'b0);
        repeat (H) @(posedge clk);
        for (int i = 0; i < max_pulses; i++) begin
            @(posedge clk);
            #1;
            if (i == 10 && ack) dev_d_drv = 1;
            if (i == 10) fall11_cyc = cyc;
            dev_c_drv = 1;
            repeat (H) @(posedge clk);
            #1 dev_c_drv = 0;
            repeat (H / 2) @(posedge clk);
            @(negedge clk);
            if (i < 10) bits[i] = ps2d;
            if (glitch && i == 3) begin
                @(posedge clk);
                #1 dev_c_drv = 1;
                repeat (3) @(posedge clk);
                #1 dev_c_drv = 0;
            end
            repeat (H / 2 - 1) @(posedge clk);
            pulse_cnt++;
        end
        dev_d_drv = 0;
    endtask

    task automatic pulse_wr(input logic [7:0] d);
        @(posedge clk);
        #1;
        din    = d;
        wr_ps2 = 1;
        @(posedge clk);
        #1 wr_ps2 = 0;
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input bit glitch,
                             input bit extra, input string tag, output logic [9:0] bits);
        int rl;
        bit so;
        int t;
        cur_ack    = ack;
        done_cnt   = 0;
        fall11_cyc = -1000;
        pulse_cnt  = 0;
        fork
            begin
                pulse_wr(d);
                if (extra) begin
                    t = 0;
                    while (pulse_cnt < 4 && t < 2000) begin
                        @(posedge clk);
                        t++;
                    end
                    pulse_wr(~d);
                end
            end
            device_frame(11, ack, glitch, bits, rl, so);
        join
        repeat (30) @(negedge clk);
        chk({tag, "_rts_len"}, rl, RTS);
        chk({tag, "_start_bit"}, so, 1);
        chk({tag, "_data"}, bits[7:0], d);
        chk({tag, "_parity"}, bits[8], exp_par(d));
        chk({tag, "_stop"}, bits[9], 1);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_ack_err"}, ack_err, !ack);
        chk({tag, "_tx_idle"}, tx_idle, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] b;
        logic [9:0] pb;
        int rl;
        bit so;
        reset     = 1;
        wr_ps2    = 0;
        din       = 0;
        dev_c_drv = 0;
        dev_d_drv = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_idle", tx_idle, 1);
        chk("rst_done", tx_done_tick, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_ps2c", ps2c, 1);
        chk("rst_ps2d", ps2d, 1);
        @(posedge clk);
        #1 reset = 0;
        repeat (20) @(posedge clk);

        chk("par_ff", exp_par(8'hFF), 1);
        chk("par_f4", exp_par(8'hF4), 0);

        run_frame(8'hFF, 1, 0, 0, "ff", b);
        chk("ff_frame_bits", b, 10'h3FF);
        run_frame(8'hF4, 1, 0, 0, "f4", b);
        chk("f4_frame_bits", b, 10'h2F4);

        run_frame(8'($urandom), 0, 0, 0, "noack", b);
        run_frame(8'($urandom), 1, 0, 0, "ack_clear", b);

        run_frame(8'($urandom), 1, 0, 1, "extra_wr", b);
        repeat (50) @(negedge clk);

        // reset in the middle of the data phase
        cur_ack   = 1;
        pulse_cnt = 0;
        fork
            pulse_wr(8'($urandom));
            device_frame(5, 1, 0, pb, rl, so);
        join
        @(posedge clk);
        #1 reset = 1;
        #1;
        chk("midrst_ps2c", ps2c, 1);
        chk("midrst_ps2d", ps2d, 1);
        chk("midrst_tx_idle", tx_idle, 1);
        chk("midrst_done", tx_done_tick, 0);
        chk("midrst_ack_err", ack_err, 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        repeat (20) @(posedge clk);
        run_frame(8'($urandom), 1, 0, 0, "after_rst", b);

        run_frame(8'($urandom), 1, 1, 0, "glitch", b);

        for (int k = 0; k < 4; k++) begin
            run_frame(8'($urandom), 1'($urandom_range(0, 1)), 0, 0, "rand", b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
